// File: rtl/calc_pkg.sv
// Shared calculator datapath types: serial subtractor state encoding and default width.
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - bin, with borrow out.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial |A-B| with separate sign: one SUB pass, plus a serial two's-complement
// pass (NEG) when the raw difference borrows.
module serial_subtractor
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_neg,
    output logic             o_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             neg_q, neg_d;
    logic             zero_q, zero_d;

    logic             d_s;
    logic             bout_s;
    logic             n_s;
    logic             last_s;

    full_subtractor u_fs (
        .i_a    (a_sh_q[0]),
        .i_b    (b_sh_q[0]),
        .i_bin  (borrow_q),
        .o_diff (d_s),
        .o_bout (bout_s)
    );

    assign n_s    = ~r_sh_q[0] ^ carry_q;
    assign last_s = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath shift logic.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        carry_d  = carry_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d  = SUB;
                    a_sh_d   = i_a;
                    b_sh_d   = i_b;
                    r_sh_d   = {WIDTH{1'b0}};
                    borrow_d = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            SUB: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                r_sh_d   = {d_s, r_sh_q[WIDTH-1:1]};
                borrow_d = bout_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_s) begin
                    cnt_d = {CNT_W{1'b0}};
                    if (bout_s) begin
                        state_d = NEG;
                        carry_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = SUB;
                end
            end
            // Borrow stays set through NEG so it still reports the sign at DONE.
            NEG: begin
                r_sh_d  = {n_s, r_sh_q[WIDTH-1:1]};
                carry_d = ~r_sh_q[0] & carry_q;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_s) begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = DONE;
                end else begin
                    state_d = NEG;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs; result fields load only when DONE is entered.
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        diff_d = diff_q;
        neg_d  = neg_q;
        zero_d = zero_q;
        if (state_d == DONE) begin
            diff_d = r_sh_d;
            neg_d  = borrow_d;
            zero_d = (r_sh_d == {WIDTH{1'b0}});
        end else begin
            diff_d = diff_q;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            r_sh_q   <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            borrow_q <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_diff = diff_q;
    assign o_neg  = neg_q;
    assign o_zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: hand-computed results, latencies and handshake.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       neg;
    logic       zero;

    int n_vec;
    int n_err;

    serial_subtractor #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_diff  (diff),
        .o_neg   (neg),
        .o_zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Wait for o_done starting at cycle 1 (caller is at that negedge); returns latency.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input int exp_lat, input logic [7:0] exp_d,
                         input logic exp_n, input logic exp_z);
        int lat;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hFF; b = 8'h00;
        chk({tag, "_busy1"}, busy, 1'b1);
        wait_done(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_diff"}, diff, exp_d);
        chk({tag, "_neg"}, neg, exp_n);
        chk({tag, "_zero"}, zero, exp_z);
        @(negedge clk);
        chk({tag, "_busy_after"}, busy, 1'b0);
        chk({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        int pulses;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'd0);
        chk("rst_neg", neg, 1'b0);
        chk("rst_zero", zero, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("pos", 8'd200, 8'd55, 9, 8'd145, 1'b0, 1'b0);
        do_op("neg", 8'd55, 8'd200, 17, 8'd145, 1'b1, 1'b0);
        do_op("eq", 8'h5A, 8'h5A, 9, 8'd0, 1'b0, 1'b1);
        do_op("max", 8'd0, 8'd255, 17, 8'd255, 1'b1, 1'b0);

        // A start during SUB must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1) begin
                pulses++;
                chk("ign_lat", i + 4, 9);
            end
            @(negedge clk);
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_diff", diff, 8'd7);
        chk("ign_neg", neg, 1'b0);

        // Reset in cycle 5 of a long operation.
        @(negedge clk);
        a = 8'd55; b = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_diff", diff, 8'd0);
        chk("mid_rst_neg", neg, 1'b0);
        chk("mid_rst_zero", zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("mid_rst_nodone", pulses, 0);
        do_op("after_rst", 8'd9, 8'd4, 9, 8'd5, 1'b0, 1'b0);

        // Back-to-back: start presented in the cycle after o_done.
        @(negedge clk);
        a = 8'd55; b = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("b2b_first_lat", lat, 17);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk);
        chk("b2b_gap_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1'b1);
        chk("b2b_hold_diff", diff, 8'd145);
        chk("b2b_hold_neg", neg, 1'b1);
        wait_done(lat);
        chk("b2b_lat", lat, 9);
        chk("b2b_diff", diff, 8'd0);
        chk("b2b_zero", zero, 1'b1);
        chk("b2b_neg", neg, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
